// File: rtl/prng_pkg.sv
// prng_pkg: xoroshiro128+ constants, default seeds, FSM state type and step function
package prng_pkg;
    localparam int ROT_A = 24;
    localparam int SHIFT_B = 16;
    localparam int ROT_C = 37;
    localparam logic [63:0] DEF_SEED0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] DEF_SEED1 = 64'hFEDC_BA98_7654_3210;
    typedef enum logic {LO, HI} gen_state_t;
    typedef struct packed {
        logic [63:0] r;
        logic [63:0] s0;
        logic [63:0] s1;
    } step_t;
    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        return (x << n) | (x >> (64 - n));
    endfunction
    function automatic step_t xoro_step(input logic [63:0] s0, input logic [63:0] s1);
        logic [63:0] t;
        t = s0 ^ s1;
        return '{r: s0 + s1, s0: rotl(s0, ROT_A) ^ t ^ (t << SHIFT_B), s1: rotl(t, ROT_C)};
    endfunction
endpackage

// File: rtl/prng_if.sv
// prng_if: seed-load port plus valid/ready word stream with fill level
// master: engine side (drives out_valid/out_data/level); slave: consumer side (drives seed_* and out_ready)
interface prng_if #(parameter int DEPTH = 4);
    logic                         seed_we;
    logic [1:0]                   seed_addr;
    logic [31:0]                  seed_wdata;
    logic                         out_valid;
    logic                         out_ready;
    logic [31:0]                  out_data;
    logic [$clog2(DEPTH+1)-1:0]   level;
    modport master(input seed_we, seed_addr, seed_wdata, out_ready, output out_valid, out_data, level);
    modport slave(output seed_we, seed_addr, seed_wdata, out_ready, input out_valid, out_data, level);
endinterface

// File: rtl/prng_word_fifo.sv
// prng_word_fifo: synchronous FIFO with flush; head word presented combinationally
// clk/resetn (sync, active-low); flush clears pointers/count; push/wdata; pop; rdata = head; count/full/empty
module prng_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == FULL_C;
    assign do_pop  = pop && !empty;
    // a full buffer still accepts a push when the head leaves on the same edge
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp];
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/prng_engine.sv
// prng_engine: free-running xoroshiro128+ producing buffered 32-bit words, with run-time reseed
// clk/resetn (sync, active-low); bus.master: seed_we/seed_addr/seed_wdata in, out_valid/out_data/level out, out_ready in
import prng_pkg::*;
module prng_engine #(
    parameter logic [63:0] SEED0 = DEF_SEED0,
    parameter logic [63:0] SEED1 = DEF_SEED1,
    parameter int          DEPTH = 4
) (
    input  logic     clk,
    input  logic     resetn,
    prng_if.master   bus
);
    step_t        nx;
    logic [63:0]  s0_q, s1_q;
    logic [95:0]  shadow_q;
    logic [127:0] seed_v;
    logic [31:0]  hi_q, push_data;
    gen_state_t   state_q, state_d;
    logic         commit, pop, push, step_en, full, empty;
    assign nx     = xoro_step(s0_q, s1_q);
    assign commit = bus.seed_we && bus.seed_addr == 2'd3;
    // the committing write supplies s1[63:32] directly, bypassing the shadow
    assign seed_v = {bus.seed_wdata, shadow_q};
    assign pop    = bus.out_valid && bus.out_ready;
    assign bus.out_valid = !empty;
    always_comb begin
        state_d = state_q;
        push = 1'b0;
        step_en = 1'b0;
        push_data = hi_q;
        if (!full || pop) begin
            push = 1'b1;
            step_en = state_q == LO;
            push_data = state_q == LO ? nx.r[31:0] : hi_q;
            state_d = state_q == LO ? HI : LO;
        end
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= LO;
            s0_q <= SEED0;
            s1_q <= SEED1;
            shadow_q <= '0;
            hi_q <= '0;
        end else begin
            if (bus.seed_we && bus.seed_addr != 2'd3) shadow_q[32*bus.seed_addr +: 32] <= bus.seed_wdata;
            if (commit) begin
                state_q <= LO;
                {s1_q, s0_q} <= seed_v == '0 ? {SEED1, SEED0} : seed_v;
            end else begin
                state_q <= state_d;
                if (step_en) begin
                    s0_q <= nx.s0;
                    s1_q <= nx.s1;
                    hi_q <= nx.r[63:32];
                end
            end
        end
    end
    prng_word_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk(clk),
        .resetn(resetn),
        .flush(commit),
        .push(push && !commit),
        .pop(pop && !commit),
        .wdata(push_data),
        .rdata(bus.out_data),
        .count(bus.level),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_prng_engine.sv
// tb_prng_engine: scoreboard bench; stimulus queues expected words, negedge monitor checks every pop
module tb_prng_engine;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    prng_if #(.DEPTH(4)) bus();
    prng_engine dut(.clk(clk), .resetn(resetn), .bus(bus));
    always #5 clk = ~clk;
    logic [31:0] exp_q[$];
    int n_chk = 0;
    int n_pass = 0;
    bit skip = 1'b0;
    logic [63:0] m_s0, m_s1;
    logic [31:0] m_hi;
    bit m_phase;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask
    function automatic void model_seed(input logic [63:0] a, input logic [63:0] b);
        m_s0 = a;
        m_s1 = b;
        m_phase = 1'b0;
    endfunction
    function automatic logic [31:0] model_word();
        logic [63:0] r, t;
        if (m_phase) begin
            m_phase = 1'b0;
            return m_hi;
        end
        r = m_s0 + m_s1;
        t = m_s0 ^ m_s1;
        m_s0 = {m_s0[39:0], m_s0[63:40]} ^ t ^ {t[47:0], 16'h0};
        m_s1 = {t[26:0], t[63:27]};
        m_hi = r[63:32];
        m_phase = 1'b1;
        return r[31:0];
    endfunction
    task automatic expect_model(input int n);
        repeat (n) exp_q.push_back(model_word());
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic seed_write(input logic [1:0] a, input logic [31:0] d);
        bus.seed_we = 1'b1;
        bus.seed_addr = a;
        bus.seed_wdata = d;
        tick();
        bus.seed_we = 1'b0;
    endtask
    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick();
        bus.out_ready = 1'b0;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask
    always @(negedge clk) begin
        if (resetn && !skip && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("unexpected_word", bus.out_data, 32'hxxxx_xxxx);
            else check("word", bus.out_data, exp_q.pop_front());
        end
    end
    initial begin
        bus.out_ready = 1'b0;
        bus.seed_we = 1'b0;
        bus.seed_addr = 2'd0;
        bus.seed_wdata = 32'd0;
        repeat (3) tick();
        check("reset_valid", 32'(bus.out_valid), 32'd0);
        check("reset_level", 32'(bus.level), 32'd0);
        check("reset_data", bus.out_data, 32'd0);
        resetn = 1'b1;
        tick();
        check("first_valid", 32'(bus.out_valid), 32'd1);
        check("first_level", 32'(bus.level), 32'd1);
        repeat (6) tick();
        check("bp_level", 32'(bus.level), 32'd4);
        repeat (5) tick();
        check("bp_level_hold", 32'(bus.level), 32'd4);
        model_seed(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        expect_model(12);
        drain();
        seed_write(2'd0, 32'd1);
        seed_write(2'd1, 32'd0);
        seed_write(2'd2, 32'd2);
        check("shadow_no_flush", 32'(bus.level), 32'd4);
        seed_write(2'd3, 32'd0);
        check("commit_level", 32'(bus.level), 32'd0);
        check("commit_valid", 32'(bus.out_valid), 32'd0);
        exp_q.push_back(32'h0000_0003);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0103_0003);
        exp_q.push_back(32'h0000_0060);
        drain();
        for (int a = 0; a < 4; a++) seed_write(2'(a), 32'd0);
        check("zero_commit_level", 32'(bus.level), 32'd0);
        model_seed(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        expect_model(10);
        drain();
        repeat (6) tick();
        check("full_before_commit", 32'(bus.level), 32'd4);
        seed_write(2'd0, 32'd5);
        seed_write(2'd1, 32'd0);
        seed_write(2'd2, 32'd7);
        bus.seed_we = 1'b1;
        bus.seed_addr = 2'd3;
        bus.seed_wdata = 32'd0;
        bus.out_ready = 1'b1;
        skip = 1'b1;
        tick();
        bus.seed_we = 1'b0;
        skip = 1'b0;
        check("commit_pop_level", 32'(bus.level), 32'd0);
        check("commit_pop_valid", 32'(bus.out_valid), 32'd0);
        exp_q.push_back(32'h0000_000C);
        exp_q.push_back(32'h0000_0000);
        model_seed(64'd5, 64'd7);
        void'(model_word());
        void'(model_word());
        expect_model(8);
        drain();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        model_seed(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        expect_model(1000);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            check("tput_valid", 32'(bus.out_valid), 32'd1);
        end
        drain();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        model_seed(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        expect_model(37);
        drain();
        repeat (3) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("midreset_level", 32'(bus.level), 32'd0);
        model_seed(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        expect_model(8);
        drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/prng_engine.md
# prng_engine

Free-running xoroshiro128+ generator with a word buffer, sitting directly upstream of the `prng` bus peripheral. It produces 32-bit random words on a valid/ready stream so the peripheral can pop one word per bus read without stalling. It also exposes a seed-load port for reseeding the 128-bit state at run time.

## Interface
- `SEED0`, default 64'h0123_4567_89AB_CDEF: reset and substitute value of state word s0.
- `SEED1`, default 64'hFEDC_BA98_7654_3210: reset and substitute value of state word s1.
- `DEPTH`, default 4: buffer depth in 32-bit words; power of two, ≥2.
- `clk`  in  1: clock; all logic rising-edge.
- `resetn`  in  1: reset, synchronous, active-low.
- `seed_we`  in  1: seed word write strobe.
- `seed_addr`  in  2: shadow word select. 0 = s0[31:0], 1 = s0[63:32], 2 = s1[31:0], 3 = s1[63:32]; a write to 3 commits.
- `seed_wdata`  in  32: seed word.
- `out_valid`  out  1: buffer non-empty.
- `out_ready`  in  1: consumer pops the head word when `out_valid` is also high.
- `out_data`  out  32: head word; only meaningful while `out_valid` is high.
- `level`  out  $clog2(DEPTH+1): words currently buffered.

## Operation
- Step function, all arithmetic mod 2^64:
  - r = s0 + s1;
  - t = s0 ^ s1;
  - s0' = rotl(s0,24) ^ t ^ (t<<16);
  - s1' = rotl(t,37).
- FSM, two states:
  - LO: if the buffer is not full, or a pop happens this cycle, apply the step, push r[31:0], latch r[63:32] into `hi_q`, go to HI. Otherwise hold.
  - HI: if the buffer is not full, or a pop happens this cycle, push `hi_q`, go to LO. Otherwise hold.
- Word order is always low half then high half; no word is ever dropped or duplicated while the buffer is full.
- Buffer:
  - Synchronous FIFO; `out_data` comes combinationally from head storage.
  - Push and pop in the same cycle are both allowed, including when the buffer is full; `level` is unchanged in that case.
- Seeding:
  - A `seed_we` write to addresses 0–2 updates only the shadow register; generation continues undisturbed.
  - A `seed_we` write to address 3 commits on that edge:
    - s0/s1 load from the shadow, with address 3's data taking effect in the same cycle;
    - the buffer is flushed to `level`=0;
    - the FSM goes to LO;
    - any push or pop in that cycle is discarded.
  - If the committed 128-bit value is all zero, s0/s1 load SEED0/SEED1 instead.
- Reset values:
  - s0=SEED0, s1=SEED1, shadow=0;
  - FSM in LO, buffer empty;
  - `out_valid`=0, `level`=0, `out_data`=0.

## Timing
- First word: the first edge with `resetn`=1 pushes it; `out_valid`=1 in the following cycle.
- Throughput: 1 word per cycle sustained with `out_ready` held high; `out_valid` never drops after the first word.
- Commit: `out_valid`=0 in the cycle after the commit edge. The first word from the new seed is valid one cycle later.
- Reset mid-operation: the state returns to SEED0/SEED1 and buffered words are lost. The output sequence restarts identically to power-on.
- Simultaneous events: commit beats pop and push; reset beats everything.

## Structure
- Package `prng_pkg`:
  - rotation constants 24/16/37;
  - default seed localparams;
  - pure function `xoro_step(s0,s1)` returning {r, s0', s1'}.
- Sub-module `prng_word_fifo` (params DEPTH, WIDTH=32) holds:
  - storage, read and write pointers, and count;
  - a synchronous flush input.
- Top level holds the state registers, the shadow register, `hi_q`, and the FSM.

## Test plan
- Seed sequence: write shadow 1, 0, 2, 0 (addresses 0–3), then pop continuously. Required words, in order: 0x00000003, 0x00000000, 0x01030003, 0x00000060.
- Back-pressure: hold `out_ready`=0 after reset. `level` climbs to 4 and holds. After release, the popped sequence matches a free-running golden model, with no gaps or repeats.
- Zero seed: commit all-zero shadow. The output sequence equals the post-reset sequence from SEED0/SEED1.
- Commit with buffer full and a simultaneous pop: `level`=0 in the next cycle, and the first new word equals r[31:0] of the new seed.
- Throughput: with `out_ready`=1, `out_valid`=1 every cycle from cycle 2 for 1000 cycles, checked against the model.
- Reset mid-stream after 37 pops: the outputs repeat the power-on sequence from word 0.
